audio_wr_burst_buf: RTL and testbench

Upstream feeder for the DDR write interconnect. Packs 16-bit audio samples into 256-bit DDR words, first sample in the LSBs. Holds the packed words in a show-ahead FIFO. Raises `channel1_rready` whenever at least one full AXI burst of words is available. The write interconnect then drains words by asserting `channel1_rd_en` during its write-data phase.

---
 rtl/audio_wr_burst_buf.sv | 124 ++++++++++++
 tb/tb_audio_wr_burst_buf.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_wr_burst_buf.sv
// Packs audio samples into DDR-width words (first sample in the LSBs) and buffers them
// in a show-ahead FIFO; raises channel1_rready once a full write burst is queued.
module audio_wr_burst_buf #(
    parameter int DQ_WIDTH     = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BURST_LEN    = 16,
    parameter int FIFO_AW      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] audio_data_in,
    input  logic                    audio_data_valid,
    input  logic                    pad_flush,
    input  logic                    buf_clear,
    output logic                    channel1_rready,
    output logic [DQ_WIDTH*8-1:0]   channel1_data,
    input  logic                    channel1_rd_en,
    output logic [FIFO_AW:0]        fifo_level,
    output logic                    overflow
);
    localparam int WW    = DQ_WIDTH * 8;
    localparam int SPW   = WW / SAMPLE_WIDTH;
    localparam int CW    = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [CW-1:0]      pcnt_q, pcnt_d;
    logic [WW-1:0]      asm_q, asm_d, word_c;
    logic               pk_push;
    logic               pv_q, pv_d;
    logic [WW-1:0]      pw_q;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [FIFO_AW:0]   level_q, level_d, remain;
    logic [WW-1:0]      data_q, data_d;
    logic               rready_q, ovf_q, ovf_d;
    logic               pop, push_ok;
    logic [WW-1:0]      mem [DEPTH];

    // Packer: the lanes above the fill point stay zero because the assembly
    // register is cleared after every push, so a padded word needs no masking.
    always_comb begin
        word_c = asm_q;
        for (int k = 0; k < SPW; k++) begin
            if (audio_data_valid && pcnt_q == CW'(k))
                word_c[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = audio_data_in;
        end
        pk_push = (audio_data_valid && pcnt_q == CW'(SPW - 1)) ||
                  (pad_flush && (pcnt_q != '0 || audio_data_valid));
        pcnt_d = pcnt_q;
        asm_d  = word_c;
        if (pk_push) begin
            pcnt_d = '0;
            asm_d  = '0;
        end else if (audio_data_valid) begin
            pcnt_d = pcnt_q + CW'(1);
        end
        pv_d = pk_push;
        if (buf_clear) begin
            pcnt_d = '0;
            asm_d  = '0;
            pv_d   = 1'b0;
        end
    end

    // FIFO control; the head is kept in a register so channel1_data is show-ahead.
    always_comb begin
        pop      = channel1_rd_en && (level_q != '0);
        push_ok  = pv_q && ((level_q != (FIFO_AW+1)'(DEPTH)) || pop);
        rd_nxt   = rd_ptr_q + FIFO_AW'(1);
        remain   = level_q - {{FIFO_AW{1'b0}}, pop};
        level_d  = remain + {{FIFO_AW{1'b0}}, push_ok};
        rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        ovf_d    = ovf_q || (pv_q && !push_ok);
        data_d   = data_q;
        if (push_ok && remain == '0)
            data_d = pw_q;
        else if (pop && level_q > (FIFO_AW+1)'(1))
            data_d = mem[rd_nxt];
        if (buf_clear) begin
            level_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
            data_d   = data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q   <= '0;
            asm_q    <= '0;
            pv_q     <= 1'b0;
            pw_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            rready_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            asm_q    <= asm_d;
            pv_q     <= pv_d;
            pw_q     <= word_c;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            rready_q <= (level_d >= (FIFO_AW+1)'(BURST_LEN));
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately unreset.
    always_ff @(posedge clk) begin
        if (push_ok && !buf_clear)
            mem[wr_ptr_q] <= pw_q;
    end

    assign channel1_rready = rready_q;
    assign channel1_data   = data_q;
    assign fifo_level      = level_q;
    assign overflow        = ovf_q;
endmodule

// File: tb/tb_audio_wr_burst_buf.sv
// Directed bench for audio_wr_burst_buf: packing order, pad flush, burst threshold,
// overflow, concurrent push/pop, clear and asynchronous reset.
module tb_audio_wr_burst_buf;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  din = '0;
    logic         valid = 1'b0;
    logic         pad = 1'b0;
    logic         clr = 1'b0;
    logic         rready;
    logic [255:0] data;
    logic         rd_en = 1'b0;
    logic [6:0]   level;
    logic         ovf;

    int nvec = 0;
    int nerr = 0;

    audio_wr_burst_buf dut (
        .clk(clk), .rst(rst),
        .audio_data_in(din), .audio_data_valid(valid),
        .pad_flush(pad), .buf_clear(clr),
        .channel1_rready(rready), .channel1_data(data),
        .channel1_rd_en(rd_en), .fifo_level(level), .overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            din   = 16'(start + i);
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
    endtask

    function automatic logic [255:0] mkword(input int base, input int n);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 16; k++)
            if (k < n) w[k*16 +: 16] = 16'(base + k);
        return w;
    endfunction

    task automatic clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b1;
        step();
        chk("rst_rready", 256'(rready), 256'(0));
        chk("rst_level",  256'(level),  256'(0));
        chk("rst_ovf",    256'(ovf),    256'(0));
        chk("rst_data",   data,         256'(0));

        // pop on an empty FIFO is ignored
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("empty_pop_level", 256'(level), 256'(0));
        chk("empty_pop_data",  data,        256'(0));

        // 1: single word ordering
        feed(1, 16);
        chk("t1_level_lat", 256'(level), 256'(0));
        step();
        chk("t1_level",  256'(level),        256'(1));
        chk("t1_lane0",  256'(data[15:0]),   256'(16'h0001));
        chk("t1_lane15", 256'(data[255:240]), 256'(16'h0010));
        chk("t1_word",   data,               mkword(1, 16));
        chk("t1_rready", 256'(rready),       256'(0));
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t1_pop_level", 256'(level), 256'(0));

        // 2: burst threshold and ordered drain
        feed(16'h0100, 240);
        step();
        chk("t2_rready15", 256'(rready), 256'(0));
        feed(16'h0100 + 240, 16);
        step();
        chk("t2_level16",  256'(level),  256'(16));
        chk("t2_rready16", 256'(rready), 256'(1));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_pop%0d", i), data, mkword(16'h0100 + 16*i, 16));
            rd_en = 1'b1;
            step();
            if (i == 0) chk("t2_rready_fall", 256'(rready), 256'(0));
        end
        rd_en = 1'b0;
        chk("t2_level0",  256'(level),  256'(0));
        chk("t2_rready0", 256'(rready), 256'(0));

        // 3: pad flush
        feed(16'h00A0, 5);
        pad = 1'b1; step(); pad = 1'b0;
        step();
        chk("t3_pad_level", 256'(level), 256'(1));
        chk("t3_pad_word",  data,        mkword(16'h00A0, 5));
        pad = 1'b1; step(); pad = 1'b0;
        step();
        chk("t3_pad_empty", 256'(level), 256'(1));
        feed(16'h0B00, 15);
        din = 16'h0B0F; valid = 1'b1; pad = 1'b1;
        step();
        valid = 1'b0; pad = 1'b0;
        step(); step();
        chk("t3_pad_last", 256'(level), 256'(2));
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t3_full_word", data, mkword(16'h0B00, 16));
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t3_drain", 256'(level), 256'(0));

        // 4: overflow, then the same with a coinciding pop
        feed(0, 1024);
        step();
        chk("t4_full",     256'(level), 256'(64));
        chk("t4_ovf_pre",  256'(ovf),   256'(0));
        feed(2000, 16);
        step();
        chk("t4_drop_lvl", 256'(level), 256'(64));
        chk("t4_ovf",      256'(ovf),   256'(1));
        chk("t4_head",     data,        mkword(0, 16));
        clear();
        chk("t4_clr_ovf",  256'(ovf),   256'(0));
        chk("t4_clr_lvl",  256'(level), 256'(0));
        feed(0, 1024);
        feed(3000, 16);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t4_pp_lvl",  256'(level), 256'(64));
        chk("t4_pp_ovf",  256'(ovf),    256'(0));
        chk("t4_pp_head", data,         mkword(16, 16));
        clear();

        // 5: simultaneous push and pop
        feed(16'h0100, 160);
        step();
        chk("t5_lvl10", 256'(level), 256'(10));
        feed(16'h0800, 16);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t5_pp_lvl",  256'(level), 256'(10));
        chk("t5_pp_head", data,         mkword(16'h0110, 16));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t5_pop%0d", i), data,
                (i < 9) ? mkword(16'h0110 + 16*i, 16) : mkword(16'h0800, 16));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk("t5_empty", 256'(level), 256'(0));
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("t5_idle_lvl",  256'(level), 256'(0));
        chk("t5_idle_data", data,        mkword(16'h0800, 16));

        // 6: clear with pending pop and sample, then async reset mid-pop
        feed(16'h4000, 327);
        step();
        chk("t6_lvl20",   256'(level),  256'(20));
        chk("t6_rready",  256'(rready), 256'(1));
        clr = 1'b1; rd_en = 1'b1; valid = 1'b1; din = 16'hDEAD;
        step();
        clr = 1'b0; rd_en = 1'b0; valid = 1'b0;
        chk("t6_clr_lvl",    256'(level),  256'(0));
        chk("t6_clr_rready", 256'(rready), 256'(0));
        chk("t6_clr_ovf",    256'(ovf),    256'(0));
        feed(16'h5000, 16);
        step();
        chk("t6_clean_lvl",  256'(level), 256'(1));
        chk("t6_clean_word", data,        mkword(16'h5000, 16));
        feed(16'h6000, 256);
        step();
        chk("t6_lvl17", 256'(level), 256'(17));
        rd_en = 1'b1;
        step();
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_lvl",    256'(level),  256'(0));
        chk("t6_rst_rready", 256'(rready), 256'(0));
        chk("t6_rst_ovf",    256'(ovf),    256'(0));
        chk("t6_rst_data",   data,         256'(0));
        rd_en = 1'b0;
        #10 rst = 1'b1;
        step();
        chk("t6_post_lvl", 256'(level), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
